// File: rtl/lut_neuron_array_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lut_neuron_array_if : config, input and output handshake bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
interface lut_neuron_array_if #(
   parameter int N_NEURONS = 4,
   parameter int IN_BITS   = 6,
   parameter int OUT_BITS  = 2
);
   localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

   logic                          cfg_we;
   logic [NW-1:0]                 cfg_neuron;
   logic [IN_BITS-1:0]            cfg_addr;
   logic [OUT_BITS-1:0]           cfg_data;
   logic                          in_valid;
   logic                          in_ready;
   logic [N_NEURONS*IN_BITS-1:0]  in_data;
   logic                          out_valid;
   logic                          out_ready;
   logic [N_NEURONS*OUT_BITS-1:0] out_data;

   modport master (
      output cfg_we, cfg_neuron, cfg_addr, cfg_data,
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  cfg_we, cfg_neuron, cfg_addr, cfg_data,
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface
`default_nettype wire

// File: rtl/lut_neuron_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lut_neuron_array : N runtime-writable truth tables, registered lookup
// Revision: 1.0
// ---------------------------------------------------------------------------
module lut_neuron_array #(
   parameter int N_NEURONS = 4,
   parameter int IN_BITS   = 6,
   parameter int OUT_BITS  = 2
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   lut_neuron_array_if.slave  bus
);
   localparam int DEPTH = 2 ** IN_BITS;

   logic [OUT_BITS-1:0]           table_q [N_NEURONS][DEPTH];
   logic [OUT_BITS-1:0]           table_d [N_NEURONS][DEPTH];
   logic                          out_valid_q, out_valid_d;
   logic [N_NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
   logic [N_NEURONS*OUT_BITS-1:0] lookup;
   logic                          accept;
   logic                          cfg_hit;

   assign bus.in_ready  = !out_valid_q || bus.out_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign accept        = bus.in_valid && bus.in_ready;
   assign cfg_hit       = bus.cfg_we && (int'(bus.cfg_neuron) < N_NEURONS);

   // Reads use the pre-write table, so a same-cycle write is seen next cycle.
   for (genvar k = 0; k < N_NEURONS; k++) begin : g_lookup
      assign lookup[k*OUT_BITS +: OUT_BITS] = table_q[k][bus.in_data[k*IN_BITS +: IN_BITS]];
   end

   always_comb begin
      table_d = table_q;
      if (cfg_hit) begin
         table_d[bus.cfg_neuron][bus.cfg_addr] = bus.cfg_data;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = lookup;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int n = 0; n < N_NEURONS; n++) begin
            for (int a = 0; a < DEPTH; a++) begin
               table_q[n][a] <= '0;
            end
         end
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         table_q     <= table_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end
endmodule
`default_nettype wire
